// File: rtl/pri_encoder_latch.sv
// -----------------------------------------------------------------------------
// pri_encoder_latch
//
// Latches request lines into a pending set and hands them, one at a time, to a
// consumer as a binary index with a Valid/Ack handshake. Request bit n is
// reported as index n, so the index round-trips through the 3-to-8 one-hot
// decoder back to bit n.
//
// Optional feature (compile-time macro PRI_ENC_ROUND_ROBIN_EN):
//   undefined - fixed priority, highest set index wins.
//   defined   - round-robin: search upward from rr_ptr with wrap-around;
//               rr_ptr moves to (granted index + 1) on every acked grant.
//
// Parameters:
//   IDX_W  width of the output index
//   N_REQ  number of request lines, must equal 2**IDX_W
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   Enable    block enable; low blocks capture and grants, abandons a grant
//   Req_in    request lines, level-sampled every cycle
//   Ack       consumer accepts the current Data_out
//   Data_out  registered index of the granted request
//   Valid     Data_out holds a granted request
//   Pending   registered set of captured, not-yet-acked requests
//   Pend_cnt  registered popcount of Pending
// -----------------------------------------------------------------------------
module pri_encoder_latch #(
   parameter int IDX_W = 3,
   parameter int N_REQ = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Enable,
   input  logic [N_REQ-1:0] Req_in,
   input  logic             Ack,
   output logic [IDX_W-1:0] Data_out,
   output logic             Valid,
   output logic [N_REQ-1:0] Pending,
   output logic [IDX_W:0]   Pend_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] pend_nxt;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] data_nxt;
   logic             valid_nxt;

   function automatic logic [IDX_W:0] popcount(input logic [N_REQ-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < N_REQ; i++)
         cnt = cnt + (IDX_W+1)'(v[i]);
      return cnt;
   endfunction

`ifdef PRI_ENC_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr, rr_nxt;

   // Walk from the farthest offset back toward rr_ptr so the last hit, i.e.
   // the nearest set bit at or above rr_ptr (with wrap), is the one kept.
   // Index arithmetic wraps naturally because N_REQ == 2**IDX_W.
   function automatic logic [IDX_W-1:0] select_idx(input logic [N_REQ-1:0] v,
                                                    input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] sel;
      sel = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         idx = ptr + IDX_W'(i);
         if (v[idx])
            sel = idx;
      end
      return sel;
   endfunction

   assign sel_idx = select_idx(Pending, rr_ptr);
`else
   // Ascending scan: the highest set bit is the last one written.
   function automatic logic [IDX_W-1:0] select_idx(input logic [N_REQ-1:0] v);
      logic [IDX_W-1:0] sel;
      sel = '0;
      for (int i = 0; i < N_REQ; i++)
         if (v[i])
            sel = IDX_W'(i);
      return sel;
   endfunction

   assign sel_idx = select_idx(Pending);
`endif

   // Clear mask: the granted bit, only on the cycle it is accepted.
   always_comb begin
      clr = '0;
      if (Valid && Ack)
         clr[Data_out] = 1'b1;
   end

   // New requests are OR'd in after the clear, so a re-request in the ack
   // cycle keeps the bit pending. With Enable low the set is frozen.
   always_comb begin
      pend_nxt = Pending;
      if (Enable)
         pend_nxt = (Pending & ~clr) | Req_in;
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = Data_out;
      valid_nxt = Valid;
`ifdef PRI_ENC_ROUND_ROBIN_EN
      rr_nxt    = rr_ptr;
`endif
      if (!Enable) begin
         // Abandon any outstanding grant; its bit remains in Pending.
         state_nxt = IDLE;
         data_nxt  = '0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|Pending) begin
                  data_nxt  = sel_idx;
                  valid_nxt = 1'b1;
                  state_nxt = GRANT;
               end
            end
            GRANT: begin
               // Data_out is frozen while waiting; it keeps its value after
               // the ack, only Valid drops.
               if (Ack) begin
                  valid_nxt = 1'b0;
                  state_nxt = IDLE;
`ifdef PRI_ENC_ROUND_ROBIN_EN
                  rr_nxt    = Data_out + 1'b1;
`endif
               end
            end
            default: begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         Data_out <= '0;
         Valid    <= 1'b0;
         Pending  <= '0;
         Pend_cnt <= '0;
      end else begin
         state    <= state_nxt;
         Data_out <= data_nxt;
         Valid    <= valid_nxt;
         Pending  <= pend_nxt;
         Pend_cnt <= popcount(pend_nxt);
      end
   end

`ifdef PRI_ENC_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else
         rr_ptr <= rr_nxt;
   end
`endif

endmodule

// File: tb/tb_pri_encoder_latch.sv
module tb_pri_encoder_latch;
   localparam int IDX_W = 3;
   localparam int N_REQ = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             Enable = 1'b0;
   logic [N_REQ-1:0] Req_in = '0;
   logic             Ack = 1'b0;
   logic [IDX_W-1:0] Data_out;
   logic             Valid;
   logic [N_REQ-1:0] Pending;
   logic [IDX_W:0]   Pend_cnt;

   pri_encoder_latch #(.IDX_W(IDX_W), .N_REQ(N_REQ)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Enable   (Enable),
      .Req_in   (Req_in),
      .Ack      (Ack),
      .Data_out (Data_out),
      .Valid    (Valid),
      .Pending  (Pending),
      .Pend_cnt (Pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int v;
      int d;
      int p;
      int c;
   } exp_t;

   exp_t sb[$];
   int   grants[$];
   int   prev_valid = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: pending set as a plain bit array, grant as a flag.
   bit   mp[N_REQ];
   int   mv = 0;
   int   md = 0;
   int   mr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int model_select();
`ifdef PRI_ENC_ROUND_ROBIN_EN
      for (int i = 0; i < N_REQ; i++)
         if (mp[(mr + i) % N_REQ]) return (mr + i) % N_REQ;
`else
      for (int k = N_REQ-1; k >= 0; k--)
         if (mp[k]) return k;
`endif
      return 0;
   endfunction

   function automatic int model_pend_val();
      int s = 0;
      for (int k = 0; k < N_REQ; k++)
         if (mp[k]) s += (1 << k);
      return s;
   endfunction

   function automatic int model_pend_cnt();
      int s = 0;
      for (int k = 0; k < N_REQ; k++)
         if (mp[k]) s++;
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N_REQ; k++) mp[k] = 1'b0;
      mv = 0; md = 0; mr = 0;
   endtask

   // Advance the model by one clock edge given the inputs held for it.
   task automatic model_step(input logic en, input logic [N_REQ-1:0] req, input logic ack);
      bit np[N_REQ];
      bit acked;
      if (en) begin
         acked = (mv != 0) && ack;
         for (int k = 0; k < N_REQ; k++)
            np[k] = req[k] || (mp[k] && !(acked && k == md));
         if (mv != 0) begin
            if (ack) begin
               mv = 0;
               mr = (md + 1) % N_REQ;
            end
         end else if (model_pend_cnt() != 0) begin
            md = model_select();
            mv = 1;
         end
         for (int k = 0; k < N_REQ; k++) mp[k] = np[k];
      end else begin
         mv = 0;
         md = 0;
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected after the edge.
   task automatic step(input logic en, input logic [N_REQ-1:0] req, input logic ack);
      exp_t e;
      @(negedge clk);
      Enable = en;
      Req_in = req;
      Ack    = ack;
      model_step(en, req, ack);
      e.v = mv; e.d = md; e.p = model_pend_val(); e.c = model_pend_cnt();
      sb.push_back(e);
      @(posedge clk);
   endtask

   // Monitor: compares every post-edge output against the queued expectation
   // and logs each new grant.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("valid",    int'(Valid),    e.v);
         chk("data_out", int'(Data_out), e.d);
         chk("pending",  int'(Pending),  e.p);
         chk("pend_cnt", int'(Pend_cnt), e.c);
      end
      if (Valid && prev_valid == 0)
         grants.push_back(int'(Data_out));
      prev_valid = int'(Valid);
   end

   task automatic chk_grants(input string nm, input int exp[4], input int n);
      chk({nm, "_count"}, grants.size(), n);
      for (int i = 0; i < n && i < grants.size(); i++)
         chk($sformatf("%s_grant%0d", nm, i), grants[i], exp[i]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int exp_l[4];
      logic [N_REQ-1:0] r;
      model_reset();

      // Reset values while rst_n is held low.
      #12;
      chk("rst_valid",    int'(Valid),    0);
      chk("rst_data",     int'(Data_out), 0);
      chk("rst_pending",  int'(Pending),  0);
      chk("rst_pend_cnt", int'(Pend_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle with no requests.
      repeat (10) step(1'b1, 8'h00, 1'b0);

      // Single pulse on bit 5, held, then acked.
      grants.delete();
      step(1'b1, 8'h20, 1'b0);
      #2 chk("pulse_pending_edge1", int'(Pending), 32'h20);
      chk("pulse_valid_edge1", int'(Valid), 0);
      step(1'b1, 8'h00, 1'b0);
      #2 chk("pulse_valid_edge2", int'(Valid), 1);
      chk("pulse_data_edge2", int'(Data_out), 5);
      repeat (3) step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b1);
      #2 chk("pulse_valid_after_ack", int'(Valid), 0);
      chk("pulse_pending_after_ack", int'(Pending), 0);
      step(1'b1, 8'h00, 1'b0);
      exp_l = '{5, 0, 0, 0};
      chk_grants("pulse", exp_l, 1);

      // Three requests at once with Ack held high.
      grants.delete();
      step(1'b1, 8'h85, 1'b1);
      repeat (8) step(1'b1, 8'h00, 1'b1);
`ifdef PRI_ENC_ROUND_ROBIN_EN
      exp_l = '{7, 0, 2, 0};
`else
      exp_l = '{7, 2, 0, 0};
`endif
      chk_grants("multi", exp_l, 3);

      // Re-request in the same cycle as the ack keeps the bit pending.
      grants.delete();
      step(1'b1, 8'h04, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h04, 1'b1);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b1);
      step(1'b1, 8'h00, 1'b0);
      #2 chk("setwins_pending_final", int'(Pending), 0);
      exp_l = '{2, 2, 0, 0};
      chk_grants("setwins", exp_l, 2);

      // Enable dropped during an outstanding grant.
      grants.delete();
      step(1'b1, 8'h40, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'hFF, 1'b1);
      #2 chk("dis_valid", int'(Valid), 0);
      chk("dis_data", int'(Data_out), 0);
      chk("dis_pending", int'(Pending), 32'h40);
      step(1'b0, 8'hFF, 1'b1);
      step(1'b0, 8'hFF, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      #2 chk("reen_valid", int'(Valid), 1);
      chk("reen_data", int'(Data_out), 6);
      step(1'b1, 8'h00, 1'b1);
      step(1'b1, 8'h00, 1'b0);
      exp_l = '{6, 6, 0, 0};
      chk_grants("disable", exp_l, 2);

      // Requests 7 and 0 held high with Ack high.
      grants.delete();
      repeat (9) step(1'b1, 8'h81, 1'b1);
`ifdef PRI_ENC_ROUND_ROBIN_EN
      exp_l = '{7, 0, 7, 0};
`else
      exp_l = '{7, 7, 7, 7};
`endif
      chk_grants("held", exp_l, 4);
      repeat (6) step(1'b1, 8'h00, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         r = 8'($urandom) & 8'($urandom);
         step(($urandom_range(0, 9) != 0), r, 1'($urandom));
      end
      repeat (20) step(1'b1, 8'h00, 1'b1);

      // Asynchronous reset in the middle of a grant, away from any edge.
      step(1'b1, 8'h10, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid",    int'(Valid),    0);
      chk("async_rst_data",     int'(Data_out), 0);
      chk("async_rst_pending",  int'(Pending),  0);
      chk("async_rst_pend_cnt", int'(Pend_cnt), 0);
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      repeat (3) step(1'b1, 8'h00, 1'b1);

      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pri_encoder_latch.md
Name: pri_encoder_latch

Overview:
- Inverse of the team's 3-to-8 one-hot decoder: converts latched request lines into a binary index with a valid/ack handshake.
- Request bit n is reported as index n, so it round-trips through the decoder (index n → one-hot bit n).
- Sits between asynchronous-ish request sources (buttons, peripheral flags) and a consumer that services one request at a time.

Parameters:
- IDX_W, 3, width of the output index.
- N_REQ, 8, number of request lines. Must equal 2**IDX_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  block enable. When low, no captures and no grants.
- Req_in  input  N_REQ  request lines. Level-sampled each cycle.
- Ack  input  1  consumer accepts the current Data_out.
- Data_out  output  IDX_W  registered index of the granted request.
- Valid  output  1  Data_out holds a granted request.
- Pending  output  N_REQ  registered set of captured, not-yet-acked requests.
- Pend_cnt  output  IDX_W+1  registered popcount of Pending.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: Data_out=0, Valid=0, Pending=0, Pend_cnt=0, state=IDLE, RR pointer=0.
- Capture (Enable=1):
  - Pending <= (Pending & ~clr) | Req_in.
  - clr is one-hot of Data_out when Valid&Ack, else 0.
  - Set wins: if Req_in[k] is high in the same cycle bit k is acked, bit k stays pending.
- Pend_cnt: popcount of the next Pending value, registered alongside Pending so the two always agree.
- State machine:
  - IDLE: if Enable and Pending!=0, register Data_out = selected index, Valid<=1, go to GRANT.
  - IDLE selection uses the registered Pending only. A request captured at edge k can produce Valid after edge k+1 (latency 2 edges from Req_in to Valid).
  - GRANT: Valid=1. Data_out holds stable while Ack=0, even if higher-priority requests arrive.
  - GRANT with Ack=1: bit Data_out is cleared, Valid<=0, go to IDLE. Data_out retains its value.
  - There is always one idle cycle with Valid=0 between consecutive grants.
- Ack while Valid=0: ignored, no Pending change.
- Enable=0 (synchronous):
  - Next edge: Valid<=0, Data_out<=0, state<=IDLE.
  - Req_in is not captured and Pending is retained.
  - A grant that was outstanding is abandoned un-acked; its bit stays pending and is re-granted after Enable returns.
- Fixed priority (default): highest set index wins, bit N_REQ-1 highest.
- Pending all ones: index N_REQ-1 is granted first, then descending, one grant per 2 cycles with Ack held high.
- Reset asserted mid-grant: all state clears immediately, with no dependence on clk.

Optional Feature:
- Macro: PRI_ENC_ROUND_ROBIN_EN.
- Defined:
  - Add a registered pointer rr_ptr, reset 0. On each acked grant of index g, rr_ptr <= g+1 mod N_REQ.
  - Selection is the first set bit searching upward from rr_ptr with wrap-around (rr_ptr itself has highest priority).
  - Enable=0 does not change rr_ptr.
- Not defined: fixed priority as above, no rr_ptr logic.

Test Plan:
- Reset then Req_in=8'h00, Enable=1 for 10 cycles → Valid=0, Pending=0, Pend_cnt=0 throughout.
- Single pulse Req_in=8'b0010_0000 for 1 cycle → Pending=0x20 after edge 1, Valid=1 and Data_out=3'd5 after edge 2; held until Ack; Ack for 1 cycle → Valid=0, Pending=0.
- Req_in=8'b1000_0101 pulse, Ack always 1 (fixed priority) → grants 7, 2, 0 in order, each Valid high 1 cycle with 1-cycle gaps; Pend_cnt 3→2→1→0.
- While granting 3'd2 with Ack=1, drive Req_in=8'b0000_0100 the same cycle → bit 2 remains pending and is re-granted as 3'd2.
- Grant 3'd6 outstanding, drop Enable for 3 cycles with Req_in=0xFF → Valid=0, Data_out=0, Pending unchanged at 0x40; Enable=1 → re-grant 3'd6.
- PRI_ENC_ROUND_ROBIN_EN defined, Req_in held 8'b1000_0001, Ack=1 → grants alternate 0,7,0,7; without the macro, grants are 7 then 7 repeatedly (re-captured each cycle).
- Assert rst_n=0 mid-grant between clock edges → all outputs 0 immediately.
